// File: rtl/forwarding_unit_pkg.sv
// Shared types for the operand-bypass / hazard-detect block: stage codes,
// forwarding source codes and the per-producer pipe-register view.
package forwarding_unit_pkg;

    localparam int DATA_W          = 32;
    localparam int REG_W           = 5;
    localparam int CNT_W           = 8;
    localparam int DEF_STALL_LIMIT = 16;

    localparam logic [2:0] STG_IF   = 3'd0;
    localparam logic [2:0] STG_ID   = 3'd1;
    localparam logic [2:0] STG_EX   = 3'd2;
    localparam logic [2:0] STG_MEM  = 3'd3;
    localparam logic [2:0] STG_WB   = 3'd4;
    localparam logic [2:0] STG_NONE = 3'd7;

    typedef enum logic [2:0] {
        SIG_REGFILE  = 3'd0,
        SIG_EX_REG   = 3'd1,
        SIG_MEM_REG  = 3'd2,
        SIG_WB_REG   = 3'd3,
        SIG_MEM_PATH = 3'd4,
        SIG_ZERO     = 3'd5,
        SIG_DEFER    = 3'd6,
        SIG_STALL    = 3'd7
    } fwd_sig_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_EX,
        SRC_MEM,
        SRC_WB
    } fwd_src_e;

    typedef struct packed {
        logic              wr_en;
        logic [REG_W-1:0]  wr_reg;
        logic [2:0]        ready_stage;
        logic [DATA_W-1:0] wr_value;
    } producer_t;

endpackage

// File: rtl/forwarding_unit_if.sv
// Operand request, producer snapshot and result bundle for one GPR read port.
interface forwarding_unit_if;
    import forwarding_unit_pkg::*;

    logic [REG_W-1:0]  required_reg;
    logic [DATA_W-1:0] gpr_result;
    logic              mem_fwd_en;
    logic [DATA_W-1:0] mem_fwd_result;
    logic [2:0]        required_stage;
    logic [2:0]        pipeline_stage;

    logic              ex_wr_en,       mem_wr_en,       wb_wr_en;
    logic [REG_W-1:0]  ex_wr_reg,      mem_wr_reg,      wb_wr_reg;
    logic [2:0]        ex_ready_stage, mem_ready_stage, wb_ready_stage;
    logic [DATA_W-1:0] ex_wr_value,    mem_wr_value,    wb_wr_value;

    logic [DATA_W-1:0] forwarding_result;
    logic              stall;
    logic [2:0]        forwarding_signal;
    logic [CNT_W-1:0]  stall_streak;
    logic              stall_long;

    modport master (
        output required_reg, gpr_result, mem_fwd_en, mem_fwd_result,
               required_stage, pipeline_stage,
               ex_wr_en, ex_wr_reg, ex_ready_stage, ex_wr_value,
               mem_wr_en, mem_wr_reg, mem_ready_stage, mem_wr_value,
               wb_wr_en, wb_wr_reg, wb_ready_stage, wb_wr_value,
        input  forwarding_result, stall, forwarding_signal, stall_streak, stall_long
    );

    modport slave (
        input  required_reg, gpr_result, mem_fwd_en, mem_fwd_result,
               required_stage, pipeline_stage,
               ex_wr_en, ex_wr_reg, ex_ready_stage, ex_wr_value,
               mem_wr_en, mem_wr_reg, mem_ready_stage, mem_wr_value,
               wb_wr_en, wb_wr_reg, wb_ready_stage, wb_wr_value,
        output forwarding_result, stall, forwarding_signal, stall_streak, stall_long
    );

endinterface

// File: rtl/forwarding_unit_fwd_match.sv
// Per-producer match: does this producer own the operand, is its value already
// in the pipe register, and if not, would waiting for it force a stall.
module fwd_match
    import forwarding_unit_pkg::*;
#(
    parameter logic [2:0] PROD_STAGE = STG_EX
) (
    input  logic             i_wr_en,
    input  logic [REG_W-1:0] i_wr_reg,
    input  logic [2:0]       i_ready_stage,
    input  logic [REG_W-1:0] i_required_reg,
    input  logic [2:0]       i_required_stage,
    input  logic [2:0]       i_pipeline_stage,
    output logic             o_hit,
    output logic             o_ready,
    output logic             o_needs_stall
);

    int w_deadline;

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        o_hit         = 1'b0;
        o_ready       = 1'b0;
        o_needs_stall = 1'b0;
        // Signed arithmetic: a consumer stage earlier than the host would go negative.
        w_deadline    = int'(PROD_STAGE) + int'(i_required_stage) - int'(i_pipeline_stage);

        o_hit   = i_wr_en && (i_wr_reg == i_required_reg) && (PROD_STAGE > i_pipeline_stage);
        o_ready = i_ready_stage < PROD_STAGE;
        if (!o_ready && i_required_stage != STG_NONE && !(int'(i_ready_stage) < w_deadline))
            o_needs_stall = 1'b1;
    end

endmodule

// File: rtl/forwarding_unit.sv
// Operand bypass and hazard detect for one GPR read port, with a saturating
// consecutive-stall counter. FORWARDING_MEM_PATH_EN enables the MEM-stage load bypass.
module forwarding_unit
    import forwarding_unit_pkg::*;
#(
    parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
    input  logic              clock,
    input  logic              reset,
    forwarding_unit_if.slave  bus
);

    producer_t        w_ex, w_mem, w_wb;
    logic             w_ex_hit,  w_ex_ready,  w_ex_stall;
    logic             w_mem_hit, w_mem_ready, w_mem_stall;
    logic             w_wb_hit,  w_wb_ready,  w_wb_stall;
    logic             w_mem_path;
    fwd_src_e         w_sel;
    fwd_sig_e         w_sig;
    logic [DATA_W-1:0] w_result;
    logic             w_stall;
    logic [CNT_W-1:0] r_stall_streak;

    assign w_ex  = '{bus.ex_wr_en,  bus.ex_wr_reg,  bus.ex_ready_stage,  bus.ex_wr_value};
    assign w_mem = '{bus.mem_wr_en, bus.mem_wr_reg, bus.mem_ready_stage, bus.mem_wr_value};
    assign w_wb  = '{bus.wb_wr_en,  bus.wb_wr_reg,  bus.wb_ready_stage,  bus.wb_wr_value};

    fwd_match #(.PROD_STAGE(STG_EX)) u_match_ex (
        .i_wr_en(w_ex.wr_en), .i_wr_reg(w_ex.wr_reg), .i_ready_stage(w_ex.ready_stage),
        .i_required_reg(bus.required_reg), .i_required_stage(bus.required_stage),
        .i_pipeline_stage(bus.pipeline_stage),
        .o_hit(w_ex_hit), .o_ready(w_ex_ready), .o_needs_stall(w_ex_stall)
    );

    fwd_match #(.PROD_STAGE(STG_MEM)) u_match_mem (
        .i_wr_en(w_mem.wr_en), .i_wr_reg(w_mem.wr_reg), .i_ready_stage(w_mem.ready_stage),
        .i_required_reg(bus.required_reg), .i_required_stage(bus.required_stage),
        .i_pipeline_stage(bus.pipeline_stage),
        .o_hit(w_mem_hit), .o_ready(w_mem_ready), .o_needs_stall(w_mem_stall)
    );

    fwd_match #(.PROD_STAGE(STG_WB)) u_match_wb (
        .i_wr_en(w_wb.wr_en), .i_wr_reg(w_wb.wr_reg), .i_ready_stage(w_wb.ready_stage),
        .i_required_reg(bus.required_reg), .i_required_stage(bus.required_stage),
        .i_pipeline_stage(bus.pipeline_stage),
        .o_hit(w_wb_hit), .o_ready(w_wb_ready), .o_needs_stall(w_wb_stall)
    );

`ifdef FORWARDING_MEM_PATH_EN
    assign w_mem_path = bus.mem_fwd_en && (w_mem.ready_stage == STG_MEM);
`else
    logic w_unused_mem_fwd;
    assign w_unused_mem_fwd = ^{bus.mem_fwd_en, bus.mem_fwd_result};
    assign w_mem_path       = 1'b0;
`endif

    // Nearest producer wins; older in-flight writes to the same register are stale.
    always_comb begin
        w_sel = SRC_NONE;
        if (bus.required_reg != '0) begin
            if (w_ex_hit)       w_sel = SRC_EX;
            else if (w_mem_hit) w_sel = SRC_MEM;
            else if (w_wb_hit)  w_sel = SRC_WB;
        end
    end

    // Only the selected producer's value is ever routed, so X on the others stays out.
    always_comb begin
        w_result = bus.gpr_result;
        w_sig    = SIG_REGFILE;
        w_stall  = 1'b0;
        if (bus.required_reg == '0) begin
            w_result = '0;
            w_sig    = SIG_ZERO;
        end else begin
            unique case (w_sel)
                SRC_EX: begin
                    if (w_ex_ready) begin
                        w_result = w_ex.wr_value;
                        w_sig    = SIG_EX_REG;
                    end else if (w_ex_stall) begin
                        w_sig    = SIG_STALL;
                        w_stall  = 1'b1;
                    end else begin
                        w_sig    = SIG_DEFER;
                    end
                end
                SRC_MEM: begin
                    if (w_mem_ready) begin
                        w_result = w_mem.wr_value;
                        w_sig    = SIG_MEM_REG;
                    end else if (w_mem_path) begin
`ifdef FORWARDING_MEM_PATH_EN
                        w_result = bus.mem_fwd_result;
`endif
                        w_sig    = SIG_MEM_PATH;
                    end else if (w_mem_stall) begin
                        w_sig    = SIG_STALL;
                        w_stall  = 1'b1;
                    end else begin
                        w_sig    = SIG_DEFER;
                    end
                end
                SRC_WB: begin
                    if (w_wb_ready) begin
                        w_result = w_wb.wr_value;
                        w_sig    = SIG_WB_REG;
                    end else if (w_wb_stall) begin
                        w_sig    = SIG_STALL;
                        w_stall  = 1'b1;
                    end else begin
                        w_sig    = SIG_DEFER;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset)
            r_stall_streak <= '0;
        else if (!w_stall)
            r_stall_streak <= '0;
        else if (r_stall_streak != '1)
            r_stall_streak <= r_stall_streak + CNT_W'(1);
    end

    assign bus.forwarding_result = w_result;
    assign bus.forwarding_signal = w_sig;
    assign bus.stall             = w_stall;
    assign bus.stall_streak      = r_stall_streak;
    assign bus.stall_long        = int'(r_stall_streak) >= STALL_LIMIT;

endmodule

// File: tb/tb_forwarding_unit.sv
// Directed-vector bench for forwarding_unit; expectations are hand-derived.
// Build with or without +define+FORWARDING_MEM_PATH_EN.
module tb_forwarding_unit;
    import forwarding_unit_pkg::*;

    localparam int LIMIT = 16;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    forwarding_unit_if bus();

    forwarding_unit #(.STALL_LIMIT(LIMIT)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic set_idle();
        bus.required_reg    = '0;
        bus.gpr_result      = '0;
        bus.mem_fwd_en      = 1'b0;
        bus.mem_fwd_result  = '0;
        bus.required_stage  = STG_NONE;
        bus.pipeline_stage  = STG_ID;
        bus.ex_wr_en  = 1'b0; bus.ex_wr_reg  = '0; bus.ex_ready_stage  = '0; bus.ex_wr_value  = '0;
        bus.mem_wr_en = 1'b0; bus.mem_wr_reg = '0; bus.mem_ready_stage = '0; bus.mem_wr_value = '0;
        bus.wb_wr_en  = 1'b0; bus.wb_wr_reg  = '0; bus.wb_ready_stage  = '0; bus.wb_wr_value  = '0;
    endtask

    task automatic set_ex(input logic en, input logic [4:0] r, input logic [2:0] rdy, input logic [31:0] v);
        bus.ex_wr_en = en; bus.ex_wr_reg = r; bus.ex_ready_stage = rdy; bus.ex_wr_value = v;
    endtask

    task automatic set_mem(input logic en, input logic [4:0] r, input logic [2:0] rdy, input logic [31:0] v);
        bus.mem_wr_en = en; bus.mem_wr_reg = r; bus.mem_ready_stage = rdy; bus.mem_wr_value = v;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] r, input logic [2:0] rdy, input logic [31:0] v);
        bus.wb_wr_en = en; bus.wb_wr_reg = r; bus.wb_ready_stage = rdy; bus.wb_wr_value = v;
    endtask

    task automatic set_req(input logic [2:0] p, input logic [4:0] r, input logic [2:0] rs, input logic [31:0] gpr);
        bus.pipeline_stage = p; bus.required_reg = r; bus.required_stage = rs; bus.gpr_result = gpr;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] res, input logic [2:0] sig, input logic stl);
        #1;
        check({tag, ".result"}, bus.forwarding_result, res);
        check({tag, ".signal"}, 32'(bus.forwarding_signal), 32'(sig));
        check({tag, ".stall"},  32'(bus.stall), 32'(stl));
    endtask

    // One stalling vector: P=1, need r8 in ID, EX producer only ready at end of EX.
    task automatic drive_stall_vec();
        set_idle();
        set_req(STG_ID, 5'd8, STG_ID, 32'h0000_0AAA);
        set_ex(1'b1, 5'd8, STG_EX, 32'h0000_0EEE);
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        #1;
        check("reset.streak", 32'(bus.stall_streak), 32'd0);
        check("reset.long",   32'(bus.stall_long), 32'd0);
        expect_out("reset.comb", 32'd0, SIG_ZERO, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;

        // r0 is hardwired zero even when a producer claims to write it.
        set_idle();
        set_req(STG_ID, 5'd0, STG_EX, 32'h0000_1234);
        set_ex(1'b1, 5'd0, STG_IF, 32'h0000_DEAD);
        expect_out("zero_reg", 32'd0, SIG_ZERO, 1'b0);

        set_idle();
        set_req(STG_ID, 5'd3, STG_EX, 32'h0000_1234);
        set_ex(1'b1, 5'd8, STG_IF, 32'h0000_DEAD);
        expect_out("no_match", 32'h0000_1234, SIG_REGFILE, 1'b0);

        // Stall for three clocks.
        @(negedge clk);
        drive_stall_vec();
        expect_out("stall", 32'h0000_0AAA, SIG_STALL, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("streak3", 32'(bus.stall_streak), 32'd3);
        set_idle();
        @(negedge clk);
        check("streak_clear", 32'(bus.stall_streak), 32'd0);

        set_idle();
        set_req(STG_ID, 5'd8, STG_EX, 32'h0000_0000);
        set_ex(1'b1, 5'd8, STG_ID, 32'h0000_CAFE);
        set_mem(1'b1, 5'd8, STG_EX, 32'h0000_1111);
        expect_out("nearest", 32'h0000_CAFE, SIG_EX_REG, 1'b0);

        set_idle();
        set_req(STG_ID, 5'd9, STG_EX, 32'h0000_0099);
        set_ex(1'b1, 5'd9, STG_EX, 32'h0000_0777);
        expect_out("deferred", 32'h0000_0099, SIG_DEFER, 1'b0);

        set_idle();
        set_req(STG_ID, 5'd9, STG_NONE, 32'h0000_0055);
        set_ex(1'b1, 5'd9, STG_WB, 32'h0000_0777);
        expect_out("unused_stage", 32'h0000_0055, SIG_DEFER, 1'b0);

        // Load in MEM, consumer in EX needs it at EX.
        set_idle();
        set_req(STG_EX, 5'd4, STG_EX, 32'h0000_0044);
        set_mem(1'b1, 5'd4, STG_MEM, 32'h0000_5555);
        bus.mem_fwd_en     = 1'b1;
        bus.mem_fwd_result = 32'h0000_BEEF;
`ifdef FORWARDING_MEM_PATH_EN
        expect_out("mem_path", 32'h0000_BEEF, SIG_MEM_PATH, 1'b0);
`else
        expect_out("mem_path", 32'h0000_0044, SIG_STALL, 1'b1);
`endif

        // EX producer is not downstream of an EX-hosted instance.
        set_idle();
        set_req(STG_EX, 5'd4, STG_EX, 32'h0000_0044);
        set_ex(1'b1, 5'd4, STG_ID, 32'h0000_9999);
        set_mem(1'b1, 5'd4, STG_EX, 32'h0000_2222);
        expect_out("mem_reg", 32'h0000_2222, SIG_MEM_REG, 1'b0);

        // X on producers that lose must not leak.
        set_idle();
        set_req(STG_ID, 5'd12, STG_EX, 32'h0000_0000);
        set_ex(1'b1, 5'd11, STG_ID, 32'hxxxx_xxxx);
        set_mem(1'b1, 5'd13, STG_EX, 32'hxxxx_xxxx);
        set_wb(1'b1, 5'd12, STG_MEM, 32'h0000_3333);
        expect_out("wb_reg_xsafe", 32'h0000_3333, SIG_WB_REG, 1'b0);

        // Hit the stall_long threshold, then pull reset mid-stall.
        @(negedge clk);
        drive_stall_vec();
        repeat (LIMIT - 1) @(posedge clk);
        @(negedge clk);
        check("long_below", 32'(bus.stall_long), 32'd0);
        @(negedge clk);
        check("streak_limit", 32'(bus.stall_streak), 32'(LIMIT));
        check("long_at", 32'(bus.stall_long), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst.streak", 32'(bus.stall_streak), 32'd0);
        check("async_rst.long",   32'(bus.stall_long), 32'd0);
        check("async_rst.stall",  32'(bus.stall), 32'd1);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("restart", 32'(bus.stall_streak), 32'd1);

        // Saturation at all-ones.
        repeat (300) @(posedge clk);
        @(negedge clk);
        check("saturate", 32'(bus.stall_streak), 32'd255);
        set_idle();
        @(negedge clk);
        check("sat_clear", 32'(bus.stall_streak), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
